mine_game_ctrl: RTL and testbench

- Parametrised Minesweeper game controller for a rectangular GRID_W x GRID_H board.
- Places NUM_BOMBS bombs pseudo-randomly from a free-running LFSR on every (re)start.
- Moves a one-hot cursor, reveals and flags cells, counts reveals, and reports win/lose.
- Sits between the keyboard decoder (level-held confirm/flag/restart/udlr) and the board/display logic.

---
 rtl/mine_game_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mine_game_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_game_ctrl.sv
// Minesweeper game controller: LFSR bomb placement, cursor, reveal/flag grids, win/lose.
// Define MINE_CURSOR_WRAP_EN to make edge moves wrap within the row/column instead of clamping.
module mine_game_ctrl #(
  parameter int unsigned GRID_W    = 4,
  parameter int unsigned GRID_H    = 4,
  parameter int unsigned NUM_BOMBS = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 confirm,
  input  logic                                 flag,
  input  logic                                 restart,
  input  logic [3:0]                           udlr,
  output logic [1:0]                           wl,
  output logic                                 busy,
  output logic [GRID_W*GRID_H-1:0]             bombGrid,
  output logic [GRID_W*GRID_H-1:0]             revealGrid,
  output logic [GRID_W*GRID_H-1:0]             flagGrid,
  output logic [GRID_W*GRID_H-1:0]             cursorGrid,
  output logic [$clog2(GRID_W*GRID_H)-1:0]     cursor_idx,
  output logic [15:0]                          reveal_count
);

  localparam int unsigned N     = GRID_W * GRID_H;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned COL_W = $clog2(GRID_W);
  localparam int unsigned ROW_W = $clog2(GRID_H);
  localparam int unsigned CNT_W = $clog2(NUM_BOMBS + 1);
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(GRID_H - 1);

  typedef enum logic [2:0] {
    S_INIT, S_PLACE, S_GAME, S_WAIT, S_WIN, S_LOSE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [N-1:0]     bomb_q, bomb_d;
  logic [N-1:0]     reveal_q, reveal_d;
  logic [N-1:0]     flag_q, flag_d;
  logic [N-1:0]     cur_q, cur_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [15:0]      count_q, count_d;
  logic [CNT_W-1:0] placed_q, placed_d;
  logic [1:0]       wl_q, wl_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] cand_c;
  logic             lose_c, win_c, one_dir_c, any_key_c;

  assign lose_c    = |(bomb_q & reveal_q);
  assign win_c     = &(bomb_q | reveal_q);
  assign one_dir_c = (udlr != 4'd0) && ((udlr & (udlr - 4'd1)) == 4'd0);
  assign any_key_c = confirm | flag | (|udlr);
  assign cand_c    = lfsr_q[IDX_W-1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_INIT;
      lfsr_q   <= LFSR_SEED;
      bomb_q   <= '0;
      reveal_q <= '0;
      flag_q   <= '0;
      cur_q    <= N'(1);
      idx_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      count_q  <= '0;
      placed_q <= '0;
      wl_q     <= 2'b00;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      bomb_q   <= bomb_d;
      reveal_q <= reveal_d;
      flag_q   <= flag_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      col_q    <= col_d;
      row_q    <= row_d;
      count_q  <= count_d;
      placed_q <= placed_d;
      wl_q     <= wl_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    bomb_d   = bomb_q;
    reveal_d = reveal_q;
    flag_d   = flag_q;
    idx_d    = idx_q;
    col_d    = col_q;
    row_d    = row_q;
    count_d  = count_q;
    placed_d = placed_q;
    wl_d     = wl_q;

    unique case (state_q)
      S_INIT: begin
        bomb_d   = '0;
        reveal_d = '0;
        flag_d   = '0;
        idx_d    = '0;
        col_d    = '0;
        row_d    = '0;
        count_d  = '0;
        placed_d = '0;
        wl_d     = 2'b00;
        state_d  = S_PLACE;
      end

      S_PLACE: begin
        // Out-of-range or duplicate candidates are simply dropped; the LFSR keeps running.
        if (({1'b0, cand_c} < (IDX_W + 1)'(N)) && !bomb_q[cand_c]) begin
          bomb_d[cand_c] = 1'b1;
          placed_d       = placed_q + CNT_W'(1);
        end
        if (placed_d == CNT_W'(NUM_BOMBS)) state_d = S_GAME;
      end

      S_GAME, S_WAIT: begin
        if (lose_c) begin
          wl_d    = 2'b10;
          state_d = S_LOSE;
        end else if (win_c) begin
          wl_d    = 2'b01;
          state_d = S_WIN;
        end else if (restart) begin
          state_d = S_INIT;
        end else if (state_q == S_WAIT) begin
          if (!any_key_c) state_d = S_GAME;
        end else if (confirm) begin
          state_d = S_WAIT;
          if (!reveal_q[idx_q] && !flag_q[idx_q]) begin
            reveal_d[idx_q] = 1'b1;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end
        end else if (flag) begin
          state_d = S_WAIT;
          if (!reveal_q[idx_q]) flag_d[idx_q] = ~flag_q[idx_q];
        end else if (|udlr) begin
          state_d = S_WAIT;
          if (one_dir_c) begin
            // Row/col are tracked alongside the index so edge tests need no divider.
            if (udlr[0]) begin
              if (col_q != COL_MAX) begin
                col_d = col_q + COL_W'(1);
                idx_d = idx_q + IDX_W'(1);
              end
`ifdef MINE_CURSOR_WRAP_EN
              else begin
                col_d = '0;
                idx_d = idx_q - IDX_W'(GRID_W - 1);
              end
`endif
            end else if (udlr[1]) begin
              if (col_q != '0) begin
                col_d = col_q - COL_W'(1);
                idx_d = idx_q - IDX_W'(1);
              end
`ifdef MINE_CURSOR_WRAP_EN
              else begin
                col_d = COL_MAX;
                idx_d = idx_q + IDX_W'(GRID_W - 1);
              end
`endif
            end else if (udlr[2]) begin
              if (row_q != ROW_MAX) begin
                row_d = row_q + ROW_W'(1);
                idx_d = idx_q + IDX_W'(GRID_W);
              end
`ifdef MINE_CURSOR_WRAP_EN
              else begin
                row_d = '0;
                idx_d = idx_q - IDX_W'((GRID_H - 1) * GRID_W);
              end
`endif
            end else begin
              if (row_q != '0) begin
                row_d = row_q - ROW_W'(1);
                idx_d = idx_q - IDX_W'(GRID_W);
              end
`ifdef MINE_CURSOR_WRAP_EN
              else begin
                row_d = ROW_MAX;
                idx_d = idx_q + IDX_W'((GRID_H - 1) * GRID_W);
              end
`endif
            end
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (restart) state_d = S_INIT;
      end

      default: state_d = S_INIT;
    endcase

    cur_d  = N'(1) << idx_d;
    busy_d = (state_d == S_INIT) || (state_d == S_PLACE);
  end

  assign wl           = wl_q;
  assign busy         = busy_q;
  assign bombGrid     = bomb_q;
  assign revealGrid   = reveal_q;
  assign flagGrid     = flag_q;
  assign cursorGrid   = cur_q;
  assign cursor_idx   = idx_q;
  assign reveal_count = count_q;

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Bench for mine_game_ctrl: directed steps plus random key presses against a cell-level game model.
module tb_mine_game_ctrl;

  localparam int unsigned W     = 4;
  localparam int unsigned H     = 4;
  localparam int unsigned NB    = 3;
  localparam int unsigned N     = W * H;
  localparam int unsigned IDX_W = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             confirm = 1'b0;
  logic             flag = 1'b0;
  logic             restart = 1'b0;
  logic [3:0]       udlr = 4'd0;
  logic [1:0]       wl;
  logic             busy;
  logic [N-1:0]     bombGrid, revealGrid, flagGrid, cursorGrid;
  logic [IDX_W-1:0] cursor_idx;
  logic [15:0]      reveal_count;

  int tests = 0;
  int fails = 0;

  // Game model: cell sets, cursor row/col, count, result
  logic [N-1:0] mb, mr, mf, b0;
  int           mrow, mcol, mcnt;
  logic [1:0]   mwl;
  logic [15:0]  m_lfsr;

  mine_game_ctrl #(.GRID_W(W), .GRID_H(H), .NUM_BOMBS(NB), .LFSR_SEED(SEED)) dut (
    .clock(clock), .reset(reset), .confirm(confirm), .flag(flag), .restart(restart),
    .udlr(udlr), .wl(wl), .busy(busy), .bombGrid(bombGrid), .revealGrid(revealGrid),
    .flagGrid(flagGrid), .cursorGrid(cursorGrid), .cursor_idx(cursor_idx),
    .reveal_count(reveal_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clock) m_lfsr <= !reset ? SEED : lstep(m_lfsr);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] one;
    int idx;
    one = 1;
    idx = mrow * W + mcol;
    chk({tag, "_wl"}, 32'(wl), 32'(mwl));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_bomb"}, 32'(bombGrid), 32'(mb));
    chk({tag, "_reveal"}, 32'(revealGrid), 32'(mr));
    chk({tag, "_flag"}, 32'(flagGrid), 32'(mf));
    chk({tag, "_curgrid"}, 32'(cursorGrid), 32'(one << idx));
    chk({tag, "_idx"}, 32'(cursor_idx), 32'(idx));
    chk({tag, "_count"}, 32'(reveal_count), 32'(mcnt));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wl"}, 32'(wl), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_bomb"}, 32'(bombGrid), 32'd0);
    chk({tag, "_reveal"}, 32'(revealGrid), 32'd0);
    chk({tag, "_flag"}, 32'(flagGrid), 32'd0);
    chk({tag, "_curgrid"}, 32'(cursorGrid), 32'd1);
    chk({tag, "_idx"}, 32'(cursor_idx), 32'd0);
    chk({tag, "_count"}, 32'(reveal_count), 32'd0);
  endtask

  // Called on the first placement cycle: the model LFSR holds the first candidate.
  task automatic expect_place(input string tag);
    logic [N-1:0] s;
    logic [15:0]  v;
    int placed, k, c;
    s = '0; v = m_lfsr; placed = 0; k = 0;
    while (placed < NB && k < 1000) begin
      c = int'(v[IDX_W-1:0]);
      if (c < N && !s[c]) begin
        s[c] = 1'b1;
        placed++;
      end
      k++;
      v = lstep(v);
    end
    for (int i = 0; i < k - 1; i++) step();
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    step();
    mb = s; mr = '0; mf = '0; mrow = 0; mcol = 0; mcnt = 0; mwl = 2'b00;
    chk({tag, "_popcnt"}, 32'($countones(bombGrid)), 32'(NB));
    check_all(tag);
  endtask

  function automatic void model_move(input logic [3:0] u);
    case (u)
      4'b0001: if (mcol < W - 1) mcol++;
`ifdef MINE_CURSOR_WRAP_EN
               else mcol = 0;
`endif
      4'b0010: if (mcol > 0) mcol--;
`ifdef MINE_CURSOR_WRAP_EN
               else mcol = W - 1;
`endif
      4'b0100: if (mrow < H - 1) mrow++;
`ifdef MINE_CURSOR_WRAP_EN
               else mrow = 0;
`endif
      4'b1000: if (mrow > 0) mrow--;
`ifdef MINE_CURSOR_WRAP_EN
               else mrow = H - 1;
`endif
      default: ;
    endcase
  endfunction

  function automatic void model_action(input logic c, input logic f, input logic [3:0] u);
    int idx;
    if (mwl != 2'b00) return;
    idx = mrow * W + mcol;
    if (c) begin
      if (!mr[idx] && !mf[idx]) begin
        mr[idx] = 1'b1;
        if (mcnt < 65535) mcnt++;
      end
    end else if (f) begin
      if (!mr[idx]) mf[idx] = ~mf[idx];
    end else if (u != 4'd0) begin
      model_move(u);
    end
    if ((mb & mr) != '0) mwl = 2'b10;
    else if ((mb | mr) == {N{1'b1}}) mwl = 2'b01;
  endfunction

  task automatic press(input logic c, input logic f, input logic [3:0] u, input string tag);
    model_action(c, f, u);
    confirm = c; flag = f; udlr = u;
    step();
    confirm = 1'b0; flag = 1'b0; udlr = 4'd0;
    step();
    check_all(tag);
  endtask

  task automatic goto(input int target);
    int tr, tc;
    tr = target / W;
    tc = target % W;
    while (mcol < tc) press(1'b0, 1'b0, 4'b0001, "mv_r");
    while (mcol > tc) press(1'b0, 1'b0, 4'b0010, "mv_l");
    while (mrow < tr) press(1'b0, 1'b0, 4'b0100, "mv_d");
    while (mrow > tr) press(1'b0, 1'b0, 4'b1000, "mv_u");
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    step();
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    restart = 1'b0;
    step();
    expect_place(tag);
  endtask

  initial begin
    int t, last, nonbomb;
    logic [3:0] u;

    // Reset and first placement
    step(); step();
    check_reset_vals("rst");
    reset = 1'b1;
    step();
    expect_place("place0");
    b0 = mb;

    // Held key moves once; then edge behaviour going left
    model_action(1'b0, 1'b0, 4'b0001);
    udlr = 4'b0001;
    repeat (5) step();
    udlr = 4'd0;
    step();
    check_all("hold_right");
    press(1'b0, 1'b0, 4'b0010, "left1");
    press(1'b0, 1'b0, 4'b0010, "left2");
    press(1'b0, 1'b0, 4'b0011, "multi_dir");

    // Flag blocks reveal; unflag then reveal
    t = 0;
    while (mb[t]) t++;
    goto(t);
    press(1'b0, 1'b1, 4'd0, "flag_set");
    press(1'b1, 1'b0, 4'd0, "confirm_flagged");
    press(1'b0, 1'b1, 4'd0, "flag_clr");
    press(1'b1, 1'b0, 4'd0, "confirm_ok");
    press(1'b0, 1'b1, 4'd0, "flag_revealed");

    // Reveal a bomb: lose, then frozen
    t = 0;
    while (!mb[t]) t++;
    goto(t);
    press(1'b1, 1'b0, 4'd0, "lose");
    press(1'b1, 1'b0, 4'd0, "lose_confirm");
    press(1'b0, 1'b0, 4'b0001, "lose_move");
    press(1'b0, 1'b1, 4'd0, "lose_flag");
    do_restart("restart_lose");

    // Reveal every safe cell: win
    nonbomb = 0;
    last = 0;
    for (int i = 0; i < N; i++) if (!mb[i]) begin nonbomb++; last = i; end
    for (int i = 0; i < N; i++) begin
      if (!mb[i]) begin
        if (i == last) press(1'b1, 1'b0, 4'd0, "re_confirm");
        goto(i);
        press(1'b1, 1'b0, 4'd0, "win_reveal");
      end
    end
    chk("win_wl", 32'(wl), 32'd1);
    chk("win_count", 32'(reveal_count), 32'(N - NB));
    press(1'b1, 1'b0, 4'd0, "win_frozen");
    do_restart("restart_win");

    // Random key presses against the model
    for (int n = 0; n < 120; n++) begin
      if (mwl != 2'b00 || ($urandom % 40) == 0) begin
        do_restart("rnd_restart");
      end else begin
        case ($urandom % 6)
          0: press(1'b1, 1'b0, 4'd0, "rnd_confirm");
          1: press(1'b0, 1'b1, 4'd0, "rnd_flag");
          default: begin
            if (($urandom % 4) != 0) u = 4'b0001 << ($urandom % 4);
            else begin
              u = 4'($urandom);
              while ($countones(u) < 2) u = 4'($urandom);
            end
            press(1'b0, 1'b0, u, "rnd_move");
          end
        endcase
      end
    end
    if (mwl != 2'b00) do_restart("pre_rst");

    // Reset during placement reproduces the first board
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    reset = 1'b0;
    step();
    check_reset_vals("rst_place");
    reset = 1'b1;
    step();
    expect_place("place_after_rst");
    chk("same_board", 32'(bombGrid), 32'(b0));

    // Reset while waiting for key release
    press(1'b0, 1'b0, 4'b0001, "pre_wait");
    confirm = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_reset_vals("rst_wait");
    confirm = 1'b0;
    reset = 1'b1;
    step();
    expect_place("place_after_rst2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
